product_accumulator: RTL and testbench
======================================

# product_accumulator

Consumes the product stream of the multiplier's response port and sums consecutive products into groups. A group closes after NUM_TERMS products or on an in_last beat, whichever comes first. The block then presents one sum per group over a valid/ready handshake. It sits directly downstream of the multiplier (in_* connects to resp_*) and forms the accumulate half of a dot-product datapath.

## Interface
- PRODUCT_W, 16: width of incoming products, unsigned.
- NUM_TERMS, 4: maximum products per group, ≥ 1.
- CNT_W, $clog2(NUM_TERMS+1): width of term counter/out_terms.
- ACC_W, PRODUCT_W + $clog2(NUM_TERMS): accumulator width; may be overridden smaller.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_val  in  1  product beat valid.
- in_product  in  PRODUCT_W  product value.
- in_last  in  1  beat closes current group early; tie 0 if unused.
- in_rdy  out  1  block accepts a beat this cycle.
- out_val  out  1  group sum valid.
- out_sum  out  ACC_W  group sum.
- out_terms  out  CNT_W  number of products in the group (1..NUM_TERMS).
- out_sat  out  1  group saturated; only meaningful with the saturation feature.
- out_rdy  in  1  consumer accepts sum.

## Operation
- Two-state FSM, ACCUM and EMIT; reset enters ACCUM.
- ACCUM:
  - in_rdy = 1.
  - A beat is accepted when in_val && in_rdy.
  - On acceptance, acc <= acc + zero-extended in_product, cnt <= cnt + 1.
  - If cnt+1 == NUM_TERMS or in_last, go to EMIT.
- EMIT:
  - in_rdy = 0; out_val = 1.
  - out_sum, out_terms, out_sat are registered and held stable until out_rdy.
  - On out_val && out_rdy: acc, cnt, and sat are cleared; go to ACCUM.
- Arithmetic: unsigned. The sum is truncated to ACC_W bits, i.e. it wraps mod 2^ACC_W unless saturation is enabled. With the default ACC_W, overflow is impossible.
- Reset values: out_val 0, out_sum 0, out_terms 0, out_sat 0. in_rdy is 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-group: the partial sum and count are discarded. No out_val is produced for that group.
- in_last on a beat that also reaches NUM_TERMS: the group closes once, with out_terms = NUM_TERMS.
- in_product and in_last are ignored when the beat is not accepted.

## Timing
- out_val rises the cycle after the closing beat is accepted.
- Minimum group period is terms + 1 cycles: one bubble cycle in EMIT even with out_rdy held high.
- No combinational path from out_rdy to in_rdy, or from in_val to out_val.
- out_* is stable while out_val && !out_rdy.

## Configuration
- Macro: PRODUCT_ACC_SAT_EN.
- Defined:
  - The adder clamps to 2^ACC_W − 1 on carry-out.
  - Once clamped, the accumulator stays at all-ones for the rest of the group.
  - out_sat is set with the emitted sum when any clamp occurred in the group.
- Undefined:
  - The sum wraps mod 2^ACC_W.
  - out_sat is tied 0.
  - No saturation logic is present.

## Structure
- Package product_acc_pkg holds:
  - the state enum (ACCUM, EMIT);
  - a localparam helper for the default ACC_W computation.
- One sub-module, product_acc_adder: ACC_W-wide add with carry-out. Saturating clamp logic is compiled in only under PRODUCT_ACC_SAT_EN.
- FSM, counter, and output registers live in product_accumulator.

## Test plan
All cases use PRODUCT_W=16, NUM_TERMS=4, default ACC_W=18 unless noted.
- Beats 100, 200, 300, 400 back-to-back, out_rdy=1 → out_val one cycle after 4th accept; out_sum=1000, out_terms=4; in_rdy=0 that cycle; next beat accepted the cycle after.
- Beats 7, 9 with in_last on 9 → out_sum=16, out_terms=2.
- Group 1, 2, 3, 4 with out_rdy low for 5 cycles → out_val/out_sum=10 held; in_rdy=0 throughout; next group 5, 5, 5, 5 → out_sum=20.
- Four beats of 65025 → out_sum=260100, out_sat=0.
- ACC_W=16, beats 65025, 65025, in_last on second:
  - without macro → out_sum=64514, out_sat=0;
  - with PRODUCT_ACC_SAT_EN → out_sum=65535, out_sat=1.
- Accept 50, 60, then rst for one cycle, then four beats of 1 → no out_val for the aborted group; subsequent out_sum=4, out_terms=4.

Source files
------------

// File: rtl/product_acc_pkg.sv
// ----------------------------------------------------------------------------
// product_acc_pkg
//
// Shared definitions for the product accumulator slice:
//   - state_t            : the two accumulator FSM states (ACCUM, EMIT)
//   - acc_w_default()    : default accumulator width so that NUM_TERMS
//                          full-scale products can never overflow
//   - DEFAULT_* params   : the reference configuration of the block
// ----------------------------------------------------------------------------
package product_acc_pkg;

  // ACCUM: taking product beats into the running sum.
  // EMIT : holding one finished group sum for the consumer.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  // Summing N values of W bits needs at most W + clog2(N) bits.
  function automatic int acc_w_default(input int product_w, input int num_terms);
    return product_w + $clog2(num_terms);
  endfunction

  localparam int DEFAULT_PRODUCT_W = 16;
  localparam int DEFAULT_NUM_TERMS = 4;
  localparam int DEFAULT_ACC_W     = acc_w_default(DEFAULT_PRODUCT_W, DEFAULT_NUM_TERMS);

endpackage : product_acc_pkg

// File: rtl/product_acc_adder.sv
// ----------------------------------------------------------------------------
// product_acc_adder
//
// ACC_W-wide unsigned adder used by the accumulator datapath.
//
// Optional feature macro: PRODUCT_ACC_SAT_EN
//   defined   : on carry-out the result clamps to all-ones and 'clamped'
//               reports that a clamp happened on this addition.
//   undefined : plain modulo-2^ACC_W add; no clamp logic and no 'clamped'
//               port exist.
//
// Ports:
//   a        in  ACC_W  running accumulator value
//   b        in  ACC_W  zero-extended product
//   sum      out ACC_W  a + b (wrapped, or clamped when saturation is on)
//   clamped  out 1      carry-out occurred (saturation build only)
// ----------------------------------------------------------------------------
module product_acc_adder #(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum
`ifdef PRODUCT_ACC_SAT_EN
  ,
  output logic             clamped
`endif
);

`ifdef PRODUCT_ACC_SAT_EN
  logic [ACC_W:0] full_sum;

  // One extra bit captures the carry-out. Once the accumulator is all-ones,
  // any non-zero addend carries out again, so the clamp is naturally sticky
  // for the remainder of the group.
  assign full_sum = {1'b0, a} + {1'b0, b};
  assign clamped  = full_sum[ACC_W];
  assign sum      = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  // Truncating add: the carry simply drops off.
  assign sum = a + b;
`endif

endmodule : product_acc_adder

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
//
// Sums consecutive products from the multiplier response stream into groups.
// A group closes after NUM_TERMS products or on a beat carrying in_last,
// whichever comes first; one sum per group is then offered downstream.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. A valid source holds its payload
// stable until that transfer; ready never depends combinationally on the
// same side's valid, and out_val/in_rdy never depend on in_val/out_rdy.
//
// Optional feature macro: PRODUCT_ACC_SAT_EN
//   defined   : the sum clamps to 2^ACC_W-1 on overflow, out_sat flags any
//               clamp within the group.
//   undefined : the sum wraps mod 2^ACC_W, out_sat is tied to 0.
//
// Parameters:
//   PRODUCT_W  width of incoming products (unsigned)
//   NUM_TERMS  maximum products per group (>= 1)
//   CNT_W      width of the term counter and out_terms
//   ACC_W      accumulator width (may be overridden smaller than default)
//
// Ports:
//   clk         in  1          clock, rising edge
//   rst         in  1          synchronous active-high reset
//   in_val      in  1          product beat valid
//   in_product  in  PRODUCT_W  product value
//   in_last     in  1          beat closes the current group early
//   in_rdy      out 1          block accepts a beat this cycle
//   out_val     out 1          group sum valid
//   out_sum     out ACC_W      group sum
//   out_terms   out CNT_W      number of products in the group
//   out_sat     out 1          group saturated (saturation build only)
//   out_rdy     in  1          consumer accepts the sum
// ----------------------------------------------------------------------------
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PRODUCT_W = DEFAULT_PRODUCT_W,
  parameter int NUM_TERMS = DEFAULT_NUM_TERMS,
  parameter int CNT_W     = $clog2(NUM_TERMS + 1),
  parameter int ACC_W     = acc_w_default(PRODUCT_W, NUM_TERMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_val,
  input  logic [PRODUCT_W-1:0] in_product,
  input  logic                 in_last,
  output logic                 in_rdy,
  output logic                 out_val,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_terms,
  output logic                 out_sat,
  input  logic                 out_rdy
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext_product;
  logic [ACC_W-1:0] add_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             close_group;

  // --------------------------------------------------------------------------
  // Bring the product to accumulator width. A narrowed accumulator keeps
  // only the low product bits, which matches the mod-2^ACC_W arithmetic.
  // --------------------------------------------------------------------------
  generate
    if (ACC_W > PRODUCT_W) begin : g_zext
      assign ext_product = {{(ACC_W - PRODUCT_W){1'b0}}, in_product};
    end else if (ACC_W == PRODUCT_W) begin : g_same
      assign ext_product = in_product;
    end else begin : g_trunc
      assign ext_product = in_product[ACC_W-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Adder (wrapping or clamping depending on the build)
  // --------------------------------------------------------------------------
`ifdef PRODUCT_ACC_SAT_EN
  logic add_clamped;
  logic sat;

  product_acc_adder #(
    .ACC_W   (ACC_W)
  ) u_adder (
    .a       (acc),
    .b       (ext_product),
    .sum     (add_sum),
    .clamped (add_clamped)
  );
`else
  product_acc_adder #(
    .ACC_W   (ACC_W)
  ) u_adder (
    .a       (acc),
    .b       (ext_product),
    .sum     (add_sum)
  );
`endif

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // in_rdy is gated by rst so no beat is taken while reset is held, and it
  // is high in the very first cycle after reset releases.
  assign in_rdy      = (state == ACCUM) && !rst;
  assign accept      = in_val && in_rdy;
  assign cnt_inc     = cnt + 1'b1;
  // A beat that both fills the group and carries in_last closes it once.
  assign close_group = (cnt_inc == CNT_W'(NUM_TERMS)) || in_last;
  assign out_val     = (state == EMIT);

  // --------------------------------------------------------------------------
  // FSM, counter, accumulator and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_terms <= '0;
`ifdef PRODUCT_ACC_SAT_EN
      sat       <= 1'b0;
      out_sat   <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt_inc;
`ifdef PRODUCT_ACC_SAT_EN
            sat <= sat | add_clamped;
`endif
            if (close_group) begin
              // Results are captured here and then held untouched for the
              // whole EMIT stay, so they cannot move while out_rdy is low.
              out_sum   <= add_sum;
              out_terms <= cnt_inc;
`ifdef PRODUCT_ACC_SAT_EN
              out_sat   <= sat | add_clamped;
`endif
              state     <= EMIT;
            end
          end
        end

        EMIT: begin
          if (out_rdy) begin
            acc   <= '0;
            cnt   <= '0;
`ifdef PRODUCT_ACC_SAT_EN
            sat   <= 1'b0;
`endif
            state <= ACCUM;
          end
        end

        default: state <= ACCUM;
      endcase
    end
  end

`ifndef PRODUCT_ACC_SAT_EN
  assign out_sat = 1'b0;
`endif

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// ----------------------------------------------------------------------------
// tb_product_accumulator
//
// Two instances share clock and reset: 'a' uses the default ACC_W (18),
// 'b' overrides ACC_W to 16 so wrap/saturation behaviour is reachable.
// Inputs change 1 time unit after the rising edge; everything is observed
// on the falling edge. The reference model treats each group as a plain
// integer total of its products and applies wrap or clamp at the end.
// Build with +define+PRODUCT_ACC_SAT_EN to check the saturating variant.
// ----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int PRODUCT_W = 16;
  localparam int NUM_TERMS = 4;
  localparam int CNT_W     = 3;
  localparam int ACC_W_A   = 18;
  localparam int ACC_W_B   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                 a_in_val = 1'b0, b_in_val = 1'b0;
  logic [PRODUCT_W-1:0] a_in_product = '0, b_in_product = '0;
  logic                 a_in_last = 1'b0, b_in_last = 1'b0;
  logic                 a_in_rdy, b_in_rdy;
  logic                 a_out_val, b_out_val;
  logic [ACC_W_A-1:0]   a_out_sum;
  logic [ACC_W_B-1:0]   b_out_sum;
  logic [CNT_W-1:0]     a_out_terms, b_out_terms;
  logic                 a_out_sat, b_out_sat;
  logic                 a_out_rdy = 1'b1, b_out_rdy = 1'b1;

  product_accumulator #(
    .PRODUCT_W (PRODUCT_W),
    .NUM_TERMS (NUM_TERMS)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_val     (a_in_val),
    .in_product (a_in_product),
    .in_last    (a_in_last),
    .in_rdy     (a_in_rdy),
    .out_val    (a_out_val),
    .out_sum    (a_out_sum),
    .out_terms  (a_out_terms),
    .out_sat    (a_out_sat),
    .out_rdy    (a_out_rdy)
  );

  product_accumulator #(
    .PRODUCT_W (PRODUCT_W),
    .NUM_TERMS (NUM_TERMS),
    .ACC_W     (ACC_W_B)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_val     (b_in_val),
    .in_product (b_in_product),
    .in_last    (b_in_last),
    .in_rdy     (b_in_rdy),
    .out_val    (b_out_val),
    .out_sum    (b_out_sum),
    .out_terms  (b_out_terms),
    .out_sat    (b_out_sat),
    .out_rdy    (b_out_rdy)
  );

  // ---------------- checking ----------------
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected entry layout: {sat, terms[2:0], sum[17:0]}
  logic [21:0] exp_q0[$];
  logic [21:0] exp_q1[$];
  longint      grp_total[2];
  int          grp_cnt[2];
  bit          emitting[2];
  bit          held[2];
  logic [17:0] held_sum[2];
  logic [2:0]  held_terms[2];
  logic        held_sat[2];
  logic [17:0] last_sum[2];
  logic [2:0]  last_terms[2];
  logic        last_sat[2];

  function automatic logic [21:0] make_exp(input int u, input longint total, input int terms);
    longint maxv;
    longint v;
    logic   s;
    maxv = (u == 0) ? ((64'd1 << ACC_W_A) - 1) : ((64'd1 << ACC_W_B) - 1);
`ifdef PRODUCT_ACC_SAT_EN
    s = (total > maxv);
    v = s ? maxv : total;
`else
    s = 1'b0;
    v = total & maxv;
`endif
    return {s, 3'(terms), 18'(v)};
  endfunction

  task automatic mon_step(input int u, input logic r, input logic iv, input logic ir,
                          input logic [15:0] ip, input logic il, input logic ov,
                          input logic ordy, input logic [17:0] os, input logic [2:0] ot,
                          input logic osat);
    string       p;
    logic [21:0] e;
    int          qs;
    p = (u == 0) ? "a" : "b";
    check({p, "_out_val"}, ov, emitting[u]);
    check({p, "_in_rdy"}, ir, !emitting[u] && !r);
    if (held[u]) begin
      check({p, "_hold_sum"}, os, held_sum[u]);
      check({p, "_hold_terms"}, ot, held_terms[u]);
      check({p, "_hold_sat"}, osat, held_sat[u]);
    end
    held[u]       = ov && !ordy && !r;
    held_sum[u]   = os;
    held_terms[u] = ot;
    held_sat[u]   = osat;
    if (r) begin
      emitting[u]  = 1'b0;
      grp_total[u] = 0;
      grp_cnt[u]   = 0;
    end else begin
      if (ov && ordy) begin
        qs = (u == 0) ? exp_q0.size() : exp_q1.size();
        check({p, "_exp_avail"}, (qs != 0), 1);
        if (qs != 0) begin
          e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check({p, "_out_sum"}, os, e[17:0]);
          check({p, "_out_terms"}, ot, e[20:18]);
          check({p, "_out_sat"}, osat, e[21]);
        end
        last_sum[u]   = os;
        last_terms[u] = ot;
        last_sat[u]   = osat;
        emitting[u]   = 1'b0;
      end
      if (iv && ir) begin
        grp_total[u] += longint'(ip);
        grp_cnt[u]++;
        if (grp_cnt[u] == NUM_TERMS || il) begin
          e = make_exp(u, grp_total[u], grp_cnt[u]);
          if (u == 0) exp_q0.push_back(e);
          else        exp_q1.push_back(e);
          emitting[u]  = 1'b1;
          grp_total[u] = 0;
          grp_cnt[u]   = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, rst, a_in_val, a_in_rdy, a_in_product, a_in_last, a_out_val, a_out_rdy,
             a_out_sum, a_out_terms, a_out_sat);
    mon_step(1, rst, b_in_val, b_in_rdy, b_in_product, b_in_last, b_out_val, b_out_rdy,
             {2'b00, b_out_sum}, b_out_terms, b_out_sat);
  end

  // ---------------- out_rdy driver ----------------
  bit rdy_rand = 1'b0;
  bit rdy_fixed[2] = '{1'b1, 1'b1};

  always begin
    @(posedge clk);
    #2;
    if (rdy_rand) begin
      a_out_rdy = 1'($urandom_range(0, 1));
      b_out_rdy = 1'($urandom_range(0, 1));
    end else begin
      a_out_rdy = rdy_fixed[0];
      b_out_rdy = rdy_fixed[1];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [15:0] prod, input logic last);
    bit taken;
    int budget;
    budget = 0;
    if (u == 0) begin a_in_val = 1'b1; a_in_product = prod; a_in_last = last; end
    else        begin b_in_val = 1'b1; b_in_product = prod; b_in_last = last; end
    forever begin
      @(negedge clk);
      taken = (u == 0) ? a_in_rdy : b_in_rdy;
      tick();
      if (taken) break;
      budget++;
      if (budget > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    if (u == 0) begin a_in_val = 1'b0; a_in_last = 1'b0; end
    else        begin b_in_val = 1'b0; b_in_last = 1'b0; end
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    while ((emitting[u] || ((u == 0) ? exp_q0.size() : exp_q1.size()) != 0) && n < 100) begin
      tick();
      n++;
    end
    check("drain", emitting[u], 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_a_out_sum", a_out_sum, 0);
    check("rst_a_out_terms", a_out_terms, 0);
    check("rst_a_out_sat", a_out_sat, 0);
    check("rst_b_out_sum", b_out_sum, 0);
    check("rst_b_out_val", b_out_val, 0);
    tick();

    // Full group, back-to-back, consumer always ready
    send(0, 16'd100, 1'b0);
    send(0, 16'd200, 1'b0);
    send(0, 16'd300, 1'b0);
    send(0, 16'd400, 1'b0);
    send(0, 16'd11, 1'b1);        // accepted right after the emit bubble
    wait_idle(0);
    check("t1_sum_first", exp_q0.size(), 0);
    // last handshake was the single-term group 11
    check("t1b_sum", last_sum[0], 11);
    check("t1b_terms", last_terms[0], 1);

    // Early close via in_last
    send(0, 16'd7, 1'b0);
    send(0, 16'd9, 1'b1);
    wait_idle(0);
    check("t2_sum", last_sum[0], 16);
    check("t2_terms", last_terms[0], 2);

    // Back-pressure: consumer stalls 5 cycles
    rdy_fixed[0] = 1'b0;
    send(0, 16'd1, 1'b0);
    send(0, 16'd2, 1'b0);
    send(0, 16'd3, 1'b0);
    send(0, 16'd4, 1'b0);
    repeat (5) tick();
    check("t3_stall_val", a_out_val, 1);
    check("t3_stall_sum", a_out_sum, 10);
    rdy_fixed[0] = 1'b1;
    wait_idle(0);
    check("t3_sum", last_sum[0], 10);
    send(0, 16'd5, 1'b0);
    send(0, 16'd5, 1'b0);
    send(0, 16'd5, 1'b0);
    send(0, 16'd5, 1'b0);
    wait_idle(0);
    check("t3b_sum", last_sum[0], 20);

    // Full-scale products, no overflow at default width
    repeat (4) send(0, 16'd65025, 1'b0);
    wait_idle(0);
    check("t4_sum", last_sum[0], 260100);
    check("t4_sat", last_sat[0], 0);

    // Narrow accumulator: wrap or clamp
    send(1, 16'd65025, 1'b0);
    send(1, 16'd65025, 1'b1);
    wait_idle(1);
`ifdef PRODUCT_ACC_SAT_EN
    check("t5_sum", last_sum[1], 65535);
    check("t5_sat", last_sat[1], 1);
`else
    check("t5_sum", last_sum[1], 64514);
    check("t5_sat", last_sat[1], 0);
`endif
    check("t5_terms", last_terms[1], 2);

    // Reset in the middle of a group
    send(0, 16'd50, 1'b0);
    send(0, 16'd60, 1'b0);
    do_reset(1);
    @(negedge clk);
    check("t6_rst_sum", a_out_sum, 0);
    check("t6_rst_terms", a_out_terms, 0);
    tick();
    repeat (4) send(0, 16'd1, 1'b0);
    wait_idle(0);
    check("t6_sum", last_sum[0], 4);
    check("t6_terms", last_terms[0], 4);

    // Randomized traffic on both instances with random back-pressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int u;
      u = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) tick();
      send(u, 16'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));
    end
    rdy_rand = 1'b0;
    rdy_fixed[0] = 1'b1;
    rdy_fixed[1] = 1'b1;
    // Close any open groups, then drain
    send(0, 16'd0, 1'b1);
    send(1, 16'd0, 1'b1);
    wait_idle(0);
    wait_idle(1);
    check("end_q0_empty", exp_q0.size(), 0);
    check("end_q1_empty", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_product_accumulator
